// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag index and width constants
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NZVC_W = 4;

  // ALU_Sel encodings
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  // Bit positions inside the {N,Z,V,C} flag vector
  localparam int NZVC_N = 3;
  localparam int NZVC_Z = 2;
  localparam int NZVC_V = 1;
  localparam int NZVC_C = 0;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU with NZVC flags
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALU_Sel,
  output logic [DATA_W-1:0] Result,
  output logic [NZVC_W-1:0] NZVC
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            c;
  logic            v;

  // Result and carry/overflow per opcode; C is carry-out for add/inc and borrow for sub/dec
  always_comb begin
    sum    = '0;
    c      = 1'b0;
    v      = 1'b0;
    Result = '0;
    case (ALU_Sel)
      OP_ADD: begin
        sum    = {1'b0, A} + {1'b0, B};
        Result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = (A[MSB] == B[MSB]) && (Result[MSB] != A[MSB]);
      end
      OP_INC: begin
        sum    = {1'b0, A} + (DATA_W+1)'(1);
        Result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = !A[MSB] && Result[MSB];
      end
      OP_SUB: begin
        sum    = {1'b0, A} - {1'b0, B};
        Result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = (A[MSB] != B[MSB]) && (Result[MSB] != A[MSB]);
      end
      OP_DEC: begin
        sum    = {1'b0, A} - (DATA_W+1)'(1);
        Result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = A[MSB] && !Result[MSB];
      end
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_XOR:  Result = A ^ B;
      OP_NOT:  Result = ~A;
      default: Result = '0;
    endcase
  end

  // Pack the flag vector from the selected result
  always_comb begin
    NZVC         = '0;
    NZVC[NZVC_N] = Result[MSB];
    NZVC[NZVC_Z] = (Result == '0);
    NZVC[NZVC_V] = v;
    NZVC[NZVC_C] = c;
  end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - general register file, two async read ports, one write port
module alu_regfile #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Register storage; every entry including r0 is writable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Raw reads; bypassing of the in-flight result happens in the stage
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute/writeback stage around the combinational ALU
module alu_exec_stage #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_nzvc,
  output logic [ADDR_W-1:0] res_rd,
  output logic [3:0]        flags_q
);

  import alu_pkg::*;

  logic              accept;
  logic              wb;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [NZVC_W-1:0] alu_nzvc;

  assign cmd_ready = !res_valid || res_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign wb        = res_valid && res_ready;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr_a(cmd_ra),
    .rdata_a(rf_a),
    .raddr_b(cmd_rb),
    .rdata_b(rf_b),
    .we     (wb),
    .waddr  (res_rd),
    .wdata  (res_data)
  );

  // Operand select: the held result is newer than the register file whether or not it retires this edge
  always_comb begin
    op_a = (res_valid && (res_rd == cmd_ra)) ? res_data : rf_a;
    if (cmd_use_imm) begin
      op_b = cmd_imm;
    end else begin
      op_b = (res_valid && (res_rd == cmd_rb)) ? res_data : rf_b;
    end
  end

  alu u_alu (
    .A      (op_a),
    .B      (op_b),
    .ALU_Sel(cmd_op),
    .Result (alu_result),
    .NZVC   (alu_nzvc)
  );

  // Result holding register; a new accept overrides the retire so back-to-back keeps res_valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_nzvc  <= '0;
      res_rd    <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_nzvc  <= alu_nzvc;
      res_rd    <= cmd_rd;
    end else if (wb) begin
      res_valid <= 1'b0;
    end
  end

  // Architectural flags only change when a result retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (wb) begin
      flags_q <= res_nzvc;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed and scoreboarded bench for alu_exec_stage
module tb_alu_exec_stage;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic [1:0] cmd_rd;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_nzvc;
  logic [1:0] res_rd;
  logic [3:0] flags_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic [3:0] nzvc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_reg[4];

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .cmd_use_imm(cmd_use_imm),
    .cmd_imm    (cmd_imm),
    .cmd_rd     (cmd_rd),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_nzvc   (res_nzvc),
    .res_rd     (res_rd),
    .flags_q    (flags_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command at a negedge, wait for it to be taken, return at the following negedge
  task automatic drive(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic ui, input logic [7:0] imm, input logic [1:0] rd);
    int n;
    cmd_op      = op;
    cmd_ra      = ra;
    cmd_rb      = rb;
    cmd_use_imm = ui;
    cmd_imm     = imm;
    cmd_rd      = rd;
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    else @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference ALU using wide integer arithmetic: {N,Z,V,C,result}
  function automatic logic [11:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u = 0; s = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin u = ua + ub; s = sa + sb; end
      3'd1: begin u = ua + 1;  s = sa + 1;  end
      3'd2: begin u = ua - ub; s = sa - sb; end
      3'd3: begin u = ua - 1;  s = sa - 1;  end
      default: ;
    endcase
    case (op)
      3'd0, 3'd1: begin r = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128); end
      3'd2, 3'd3: begin r = u[7:0]; c = (u < 0);   v = (s > 127) || (s < -128); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  initial begin
    logic       last_acc;
    logic       pend_flag;
    logic [3:0] exp_flag;
    logic [11:0] ref_out;
    logic [7:0] a, b;
    exp_t       e;
    int         accepted;
    int         cyc;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_use_imm = 1'b0; cmd_imm = 8'h00; cmd_rd = 2'd0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_nzvc", res_nzvc, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Forwarded ADD chain
    drive(3'd0, 2'd0, 2'd0, 1'b1, 8'd100, 2'd1);
    chk("add1_data", res_data, 8'h64);
    chk("add1_nzvc", res_nzvc, 4'b0000);
    chk("add1_rd", res_rd, 2'd1);
    chk("add1_valid", res_valid, 1);
    drive(3'd0, 2'd1, 2'd0, 1'b1, 8'd30, 2'd2);
    chk("add2_data", res_data, 8'h82);
    chk("add2_nzvc", res_nzvc, 4'b1010);
    chk("add2_valid", res_valid, 1);
    idle();
    chk("add2_flags", flags_q, 4'b1010);
    chk("idle_valid", res_valid, 0);
    drive(3'd5, 2'd2, 2'd0, 1'b1, 8'h00, 2'd2);
    chk("read_r2", res_data, 8'h82);
    idle();

    // Signed overflow on DEC and INC
    drive(3'd0, 2'd0, 2'd0, 1'b1, 8'h80, 2'd3);
    chk("load_r3", res_data, 8'h80);
    drive(3'd3, 2'd3, 2'd2, 1'b0, 8'hFF, 2'd3);
    chk("dec_data", res_data, 8'h7F);
    chk("dec_nzvc", res_nzvc, 4'b0010);
    drive(3'd1, 2'd3, 2'd2, 1'b0, 8'hFF, 2'd3);
    chk("inc_data", res_data, 8'h80);
    chk("inc_nzvc", res_nzvc, 4'b1010);
    idle();

    // Logic ops, borrow, carry, rb forwarding
    drive(3'd0, 2'd0, 2'd0, 1'b1, 8'h4E, 2'd1);
    drive(3'd7, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2);
    chk("not_data", res_data, 8'hB1);
    chk("not_nzvc", res_nzvc, 4'b1000);
    drive(3'd6, 2'd1, 2'd0, 1'b1, 8'h4E, 2'd2);
    chk("xor_data", res_data, 8'h00);
    chk("xor_nzvc", res_nzvc, 4'b0100);
    drive(3'd0, 2'd1, 2'd0, 1'b1, 8'hC0, 2'd2);
    chk("addc_data", res_data, 8'h0E);
    chk("addc_nzvc", res_nzvc, 4'b0001);
    drive(3'd2, 2'd1, 2'd2, 1'b0, 8'h00, 2'd3);
    chk("sub_rb_fwd", res_data, 8'h40);
    drive(3'd2, 2'd1, 2'd0, 1'b1, 8'h50, 2'd2);
    chk("sub_data", res_data, 8'hFE);
    chk("sub_nzvc", res_nzvc, 4'b1001);
    idle();
    chk("sub_flags", flags_q, 4'b1001);

    // Backpressure for three cycles with a dependent command waiting
    res_ready = 1'b0;
    drive(3'd0, 2'd0, 2'd0, 1'b1, 8'h05, 2'd2);
    chk("bp_data0", res_data, 8'h05);
    cmd_op = 3'd5; cmd_ra = 2'd2; cmd_rb = 2'd0; cmd_use_imm = 1'b1; cmd_imm = 8'h10; cmd_rd = 2'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_data", res_data, 8'h05);
      chk("bp_rd", res_rd, 2'd2);
      chk("bp_valid", res_valid, 1);
      chk("bp_flags", flags_q, 4'b1001);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_data", res_data, 8'h15);
    chk("bp_next_rd", res_rd, 2'd3);
    chk("bp_wb_flags", flags_q, 4'b0000);
    idle();
    drive(3'd2, 2'd0, 2'd0, 1'b1, 8'h01, 2'd0);
    chk("sub_borrow_data", res_data, 8'hFF);
    chk("sub_borrow_nzvc", res_nzvc, 4'b1001);
    idle();

    // Asynchronous reset while a result is held
    res_ready = 1'b0;
    drive(3'd0, 2'd0, 2'd0, 1'b1, 8'h33, 2'd1);
    chk("pre_rst_data", res_data, 8'h32);
    cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_data", res_data, 0);
    chk("async_rst_nzvc", res_nzvc, 0);
    chk("async_rst_rd", res_rd, 0);
    chk("async_rst_flags", flags_q, 0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      drive(3'd5, 2'(r), 2'd0, 1'b1, 8'h00, 2'(r));
      chk("post_rst_reg", res_data, 8'h00);
    end
    idle();

    // Random stream against the architectural scoreboard
    for (int r = 0; r < 4; r++) m_reg[r] = 8'h00;
    last_acc = 1'b0;
    pend_flag = 1'b0;
    exp_flag = 4'h0;
    accepted = 0;
    cyc = 0;
    cmd_valid = 1'b0;
    while ((accepted < 200 || exp_q.size() > 0) && cyc < 3000) begin
      if (pend_flag) begin
        chk("rnd_flags", flags_q, exp_flag);
        pend_flag = 1'b0;
      end
      if (accepted >= 200) begin
        cmd_valid = 1'b0;
      end else if (!(cmd_valid && !last_acc)) begin
        cmd_op      = 3'($urandom_range(0, 7));
        cmd_ra      = 2'($urandom_range(0, 3));
        cmd_rb      = 2'($urandom_range(0, 3));
        cmd_use_imm = 1'($urandom_range(0, 1));
        cmd_imm     = 8'($urandom_range(0, 255));
        cmd_rd      = 2'($urandom_range(0, 3));
        cmd_valid   = ($urandom_range(0, 3) != 0);
      end
      res_ready = (accepted >= 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      last_acc = cmd_valid && cmd_ready;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_wb", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_data", res_data, e.data);
          chk("rnd_nzvc", res_nzvc, e.nzvc);
          chk("rnd_rd", res_rd, e.rd);
          exp_flag = e.nzvc;
          pend_flag = 1'b1;
        end
      end
      if (last_acc) begin
        a = m_reg[cmd_ra];
        b = cmd_use_imm ? cmd_imm : m_reg[cmd_rb];
        ref_out = ref_alu(cmd_op, a, b);
        m_reg[cmd_rd] = ref_out[7:0];
        e.rd = cmd_rd;
        e.data = ref_out[7:0];
        e.nzvc = ref_out[11:8];
        exp_q.push_back(e);
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    if (pend_flag) chk("rnd_flags_last", flags_q, exp_flag);
    if (cyc >= 3000) chk("rnd_timeout", 32'd1, 32'd0);
    res_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      drive(3'd5, 2'(r), 2'd0, 1'b1, 8'h00, 2'(r));
      chk("rnd_final_reg", res_data, m_reg[r]);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage wrapped around the existing combinational 8-bit ALU.
- Ports of that ALU: A, B, ALU_Sel → Result, NZVC.
- Accepts register-addressed commands from the upstream sequencer over a valid/ready handshake. Reads operands from a small register file and computes through the ALU.
- Presents a registered result and flags to the downstream consumer. Writes back to the register file when the downstream accepts.

Parameters:
- DATA_W, 8, datapath width; fixed to the ALU width, only 8 is supported.
- REG_COUNT, 4, number of general registers.
- ADDR_W, 2, register address width (clog2 of REG_COUNT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command.
- cmd_op  in  3  ALU_Sel code: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT.
- cmd_ra  in  ADDR_W  source A register.
- cmd_rb  in  ADDR_W  source B register.
- cmd_use_imm  in  1  B operand taken from cmd_imm instead of rb.
- cmd_imm  in  DATA_W  immediate operand.
- cmd_rd  in  ADDR_W  destination register.
- res_valid  out  1  result held.
- res_ready  in  1  downstream accepts result.
- res_data  out  DATA_W  registered ALU Result.
- res_nzvc  out  4  registered ALU flags {N,Z,V,C}.
- res_rd  out  ADDR_W  destination of held result.
- flags_q  out  4  architectural flags, updated at writeback.

Behaviour:
- Reset:
  - Asynchronous and active-high; takes effect immediately, regardless of clk.
  - All registers are 0. res_valid=0, res_data=0, res_nzvc=0, res_rd=0, flags_q=0.
  - cmd_ready=1 on the first cycle after release.
- Accept:
  - cmd_ready = !res_valid || res_ready (combinational; no dependency on cmd_valid).
  - A command is accepted when cmd_valid && cmd_ready at a rising edge.
- Compute:
  - Combinational in the accepting cycle.
  - A = reg[ra]; B = cmd_use_imm ? cmd_imm : reg[rb].
  - For INC, DEC and NOT, B is ignored.
  - ALU_Sel = cmd_op.
- Result register:
  - On accept: res_data ← Result, res_nzvc ← NZVC, res_rd ← cmd_rd, res_valid ← 1.
  - Latency is 1 cycle: the result is visible the cycle after accept.
- Writeback:
  - On res_valid && res_ready: reg[res_rd] ← res_data and flags_q ← res_nzvc.
  - If no new command is accepted in the same edge, res_valid ← 0.
- Back-to-back:
  - Writeback and a new accept in the same edge are allowed; res_valid stays 1.
  - Throughput is one command per cycle while res_ready=1.
- Forwarding:
  - When res_valid=1 and res_rd equals ra (or rb with !cmd_use_imm), that operand is taken from res_data instead of reg[].
  - This applies whether or not writeback fires in that cycle, so dependent commands never stall.
- Backpressure:
  - While res_valid && !res_ready, res_data, res_nzvc and res_rd are held stable, cmd_ready=0, and no register or flags_q write occurs.
- Register 0 is a normal writable register; it is not hardwired to zero.
- Arithmetic:
  - Modulo 2^8 wrap-around.
  - The flag meanings are exactly those produced by the ALU; this stage never recomputes them.
- Reset mid-operation: a held, unaccepted result is discarded and no writeback occurs.
- Commands presented while cmd_ready=0 are not consumed; upstream must hold them stable.

Decomposition:
- A shared package (alu_pkg) holds:
  - the ALU_Sel opcode constants (OP_ADD … OP_NOT);
  - the NZVC bit indices (N=3, Z=2, V=1, C=0);
  - DATA_W.
- One sub-module, alu_regfile:
  - REG_COUNT×DATA_W registers with async reset;
  - two combinational read ports and one write port;
  - no internal forwarding, which stays in alu_exec_stage.
- The ALU itself is instantiated unchanged.

Test Plan:
- Reset, then ADD ra=0 imm=100 rd=1, then ADD ra=1 imm=30 rd=2 on consecutive cycles (forwarding):
  - result 1: 0x64, nzvc=0000;
  - result 2: 0x82, nzvc=1010;
  - after both accepted, reg2=0x82 and flags_q=1010.
- Load 0x80 into r3, then DEC ra=3 rd=3 → res_data=0x7F with V=1; then INC ra=3 → 0x80 with N=1, V=1.
- NOT ra holding 0x4E → 0xB1, N=1, Z=0. XOR of 0x4E with imm 0x4E → 0x00, Z=1.
- Backpressure: hold res_ready=0 for 3 cycles after an accept:
  - res_* stable, cmd_ready=0, flags_q unchanged;
  - on release, the pending command is accepted in the same edge as writeback.
- Assert rst mid-stream with res_valid=1 and res_ready=0:
  - outputs zero immediately (before the next clk edge);
  - all registers read 0 afterwards and the discarded result is never written.
- Run a 200-command random stream against a scoreboard model; register contents and flags_q must match after every writeback.
